// File: rtl/lut_mux_fn.sv
// Runtime-programmable function generator: a 2^SEL_W-entry table of 2-bit codes
// (0, 1, rv, ~rv) is loaded serially, then indexed by sel to produce a registered f.
module lut_mux_fn #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             rv,
    input  logic             in_valid,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             f,
    output logic             f_valid
);

    // state | meaning
    // LOAD  | accepting table entries serially, evaluations ignored
    // RUN   | table frozen, in_valid evaluates table[sel] against rv

    localparam int DEPTH = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [SEL_W-1:0] idx_q;
    logic [1:0]       lut_q [DEPTH];
    logic             f_q;
    logic             f_valid_q;
    logic             cfg_done_q;
    logic [1:0]       code;
    logic             f_d;

    // Decode sees the table register directly, so a write is visible one cycle later.
    always_comb begin
        code = lut_q[sel];
        f_d  = 1'b0;
        case (code)
            2'b00: f_d = 1'b0;
            2'b01: f_d = 1'b1;
            2'b10: f_d = rv;
            2'b11: f_d = ~rv;
            default: f_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            f_q        <= 1'b0;
            f_valid_q  <= 1'b0;
            cfg_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                lut_q[i] <= 2'b00;
            end
        end else begin
            cfg_done_q <= 1'b0;
            f_valid_q  <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (cfg_start) begin
                        idx_q <= '0;
                    end else if (cfg_valid) begin
                        lut_q[idx_q] <= cfg_data;
                        if (idx_q == LAST_IDX) begin
                            idx_q      <= '0;
                            state_q    <= RUN;
                            cfg_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
                end
                RUN: begin
                    // An evaluation coinciding with cfg_start still uses the old table.
                    if (in_valid) begin
                        f_q       <= f_d;
                        f_valid_q <= 1'b1;
                    end
                    if (cfg_start) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign cfg_ready = (state_q == LOAD);
    assign cfg_done  = cfg_done_q;
    assign f         = f_q;
    assign f_valid   = f_valid_q;

endmodule

// File: tb/tb_lut_mux_fn.sv
// Scoreboard bench for lut_mux_fn: directed loads and evaluations push expected f
// values into a queue; a negedge monitor pops and compares on every f_valid.
module tb_lut_mux_fn;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic       rv;
    logic       in_valid;
    logic       cfg_start;
    logic       cfg_valid;
    logic [1:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_done;
    logic       f;
    logic       f_valid;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    lut_mux_fn #(.SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .rv        (rv),
        .in_valid  (in_valid),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .f         (f),
        .f_valid   (f_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && f_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_f_valid: got f_valid=1 with no pending evaluation, expected 0 at %0t", $time);
            end else begin
                logic e;
                e = exp_q.pop_front();
                chk("scoreboard_f", {7'b0, f}, {7'b0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input int s, input logic r, input logic exp);
        sel      = 3'(s);
        rv       = r;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    // codes holds entry i in bits [2i+1:2i]
    task automatic load8(input logic [15:0] codes, input int gap, input string tag);
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = codes[2*i +: 2];
            tick();
            cfg_valid = 1'b0;
            chk({tag, "_cfg_done"}, {7'b0, cfg_done}, {7'b0, (i == 7)});
            if (i == 7) chk({tag, "_cfg_ready_low"}, {7'b0, cfg_ready}, 8'd0);
            repeat (gap) tick();
        end
    endtask

    logic [15:0] sw_exp;

    initial begin
        rst = 1'b1; sel = '0; rv = 1'b0; in_valid = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cfg_ready", {7'b0, cfg_ready}, 8'd1);
        chk("rst_f", {7'b0, f}, 8'd0);
        chk("rst_f_valid", {7'b0, f_valid}, 8'd0);
        chk("rst_cfg_done", {7'b0, cfg_done}, 8'd0);

        // Evaluation requested in LOAD is ignored
        sel = 3'd5; rv = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("load_ignore_f", {7'b0, f}, 8'd0);
        chk("load_ignore_f_valid", {7'b0, f_valid}, 8'd0);

        // Table: e0..e7 = 00,00,01,01,01,00,01,11
        load8({2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00}, 0, "load1");
        tick();
        chk("load1_done_one_cycle", {7'b0, cfg_done}, 8'd0);

        eval(7, 1'b0, 1'b1);
        chk("sel7_rv0_valid", {7'b0, f_valid}, 8'd1);
        tick();
        chk("idle_f_valid_low", {7'b0, f_valid}, 8'd0);
        chk("idle_f_holds", {7'b0, f}, 8'd1);
        eval(7, 1'b1, 1'b0);
        eval(2, 1'b0, 1'b1);
        eval(2, 1'b1, 1'b1);
        eval(5, 1'b1, 1'b0);
        tick();

        // Back-to-back sweep over all (sel, rv); index = sel*2 + rv
        sw_exp = 16'h73F0;
        for (int k = 0; k < 16; k++) begin
            eval(k / 2, k[0], sw_exp[k]);
            in_valid = (k != 15);
            chk("sweep_f_valid", {7'b0, f_valid}, 8'd1);
        end
        in_valid = 1'b0;
        tick();

        // cfg_start with in_valid: old table evaluates, then LOAD
        cfg_start = 1'b1;
        eval(7, 1'b0, 1'b1);
        cfg_start = 1'b0;
        chk("reconf_f_valid", {7'b0, f_valid}, 8'd1);
        chk("reconf_cfg_ready", {7'b0, cfg_ready}, 8'd1);

        load8(16'hAAAA, 0, "load_rv");
        eval(3, 1'b1, 1'b1);
        eval(0, 1'b0, 1'b0);
        eval(6, 1'b1, 1'b1);
        tick();

        // Restart after 3 entries; cfg_valid alongside cfg_start is dropped
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_data = 2'b01; tick(); cfg_valid = 1'b0;
            chk("partial_cfg_done", {7'b0, cfg_done}, 8'd0);
        end
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b00;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        chk("restart_cfg_done", {7'b0, cfg_done}, 8'd0);
        load8(16'hFFFF, 1, "restart");
        eval(2, 1'b0, 1'b1);
        eval(5, 1'b1, 1'b0);
        tick();

        // Reset after 4 entries aborts the load
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_data = 2'b01; tick(); cfg_valid = 1'b0;
        end
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_cfg_done", {7'b0, cfg_done}, 8'd0);
        chk("midrst_cfg_ready", {7'b0, cfg_ready}, 8'd1);
        chk("midrst_f", {7'b0, f}, 8'd0);
        // Table: e0..e7 = 10,11,00,01,10,11,00,01, with idle gaps
        load8({2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10}, 2, "postrst");
        eval(0, 1'b1, 1'b1);
        eval(1, 1'b1, 1'b0);
        eval(3, 1'b0, 1'b1);
        eval(2, 1'b1, 1'b0);
        eval(4, 1'b0, 1'b0);
        repeat (3) tick();

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
